// File: rtl/move_cmd_if.sv
// move_cmd_if: command/handshake bundle between requesters, arbiter and mover.
// The master drives the requests and observes the arbitrated outputs; the slave (arbiter) does the reverse.
interface move_cmd_if;
  logic       startOfFrame;
  logic       kb_up, kb_down, kb_left, kb_right;
  logic       demo_up, demo_down, demo_left, demo_right;
  logic       demo_valid;
  logic       pause_key;
  logic       collision;
  logic       up_out, down_out, left_out, right_out;
  logic       move_en;
  logic [1:0] owner;
  logic       demo_active;
  modport master (
    output startOfFrame, kb_up, kb_down, kb_left, kb_right,
           demo_up, demo_down, demo_left, demo_right, demo_valid, pause_key, collision,
    input  up_out, down_out, left_out, right_out, move_en, owner, demo_active
  );
  modport slave (
    input  startOfFrame, kb_up, kb_down, kb_left, kb_right,
           demo_up, demo_down, demo_left, demo_right, demo_valid, pause_key, collision,
    output up_out, down_out, left_out, right_out, move_en, owner, demo_active
  );
endinterface

// File: rtl/move_cmd_arbiter.sv
// move_cmd_arbiter: keyboard/demo direction arbiter with pause and post-collision freeze.
// The demo path and its idle counter exist only when MOVE_ARB_DEMO_EN is defined.
module move_cmd_arbiter #(
  parameter int DEMO_IDLE_FRAMES = 300,
  parameter int FREEZE_FRAMES    = 15
) (
  input logic         clk,
  input logic         resetN,
  move_cmd_if.slave   bus
);
  typedef enum logic [1:0] {KB_ST = 2'b00, DEMO_ST = 2'b01, PAUSE_ST = 2'b10, FREEZE_ST = 2'b11} state_t;
  localparam int FW = (FREEZE_FRAMES > 0) ? $clog2(FREEZE_FRAMES + 1) : 1;
  state_t        st_q, st_d, ret_q, ret_d;
  logic [FW-1:0] frz_q, frz_d;
  logic          pause_q;
  logic [3:0]    kb, demo, dir_d;
  logic          kb_any, pedge, go_demo, dv;
  assign kb     = {bus.kb_up, bus.kb_down, bus.kb_left, bus.kb_right};
  assign kb_any = |kb;
  assign pedge  = bus.pause_key & ~pause_q;
`ifdef MOVE_ARB_DEMO_EN
  localparam int IW = (DEMO_IDLE_FRAMES > 0) ? $clog2(DEMO_IDLE_FRAMES + 1) : 1;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  assign demo     = {bus.demo_up, bus.demo_down, bus.demo_left, bus.demo_right};
  assign dv       = bus.demo_valid;
  assign idle_inc = (idle_q == IW'(DEMO_IDLE_FRAMES)) ? idle_q : idle_q + 1'b1;
  // The switch fires on the frame pulse that brings the count to the threshold.
  assign go_demo  = bus.startOfFrame & ~kb_any & dv & (idle_inc == IW'(DEMO_IDLE_FRAMES));
  assign idle_d   = (kb_any || (st_q == PAUSE_ST && pedge) || (st_q == DEMO_ST && st_d == KB_ST)) ? '0 :
                    (st_q == KB_ST && bus.startOfFrame) ? idle_inc : idle_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) idle_q <= '0;
    else         idle_q <= idle_d;
`else
  assign demo    = '0;
  assign dv      = 1'b0;
  assign go_demo = 1'b0;
`endif
  always_comb begin
    st_d  = st_q;
    ret_d = ret_q;
    frz_d = frz_q;
    case (st_q)
      KB_ST, DEMO_ST: begin
        if (pedge) begin
          st_d  = PAUSE_ST;
          ret_d = st_q;
        end else if (bus.collision && FREEZE_FRAMES > 0) begin
          st_d  = FREEZE_ST;
          ret_d = st_q;
          frz_d = FW'(FREEZE_FRAMES);
        end else if (st_q == DEMO_ST && (kb_any || !dv)) st_d = KB_ST;
        else if (st_q == KB_ST && go_demo) st_d = DEMO_ST;
      end
      PAUSE_ST: st_d = pedge ? ret_q : st_q;
      default: begin
        if (pedge) begin
          st_d  = PAUSE_ST;
          frz_d = '0;
        end else if (bus.startOfFrame) begin
          frz_d = (frz_q != '0) ? frz_q - 1'b1 : frz_q;
          st_d  = (frz_q <= FW'(1)) ? ret_q : st_q;
        end
      end
    endcase
    dir_d = (st_d == KB_ST) ? kb : (st_d == DEMO_ST) ? demo : 4'b0000;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      st_q            <= KB_ST;
      ret_q           <= KB_ST;
      frz_q           <= '0;
      pause_q         <= 1'b0;
      bus.up_out      <= 1'b0;
      bus.down_out    <= 1'b0;
      bus.left_out    <= 1'b0;
      bus.right_out   <= 1'b0;
      bus.move_en     <= 1'b0;
      bus.owner       <= 2'b00;
      bus.demo_active <= 1'b0;
    end else begin
      st_q            <= st_d;
      ret_q           <= ret_d;
      frz_q           <= frz_d;
      pause_q         <= bus.pause_key;
      {bus.up_out, bus.down_out, bus.left_out, bus.right_out} <= dir_d;
      bus.move_en     <= (st_d == KB_ST) || (st_d == DEMO_ST);
      bus.owner       <= st_d;
      bus.demo_active <= (st_d == DEMO_ST);
    end
endmodule

// File: tb/tb_move_cmd_arbiter.sv
// tb_move_cmd_arbiter: scoreboard bench for move_cmd_arbiter (DEMO_IDLE_FRAMES=4, FREEZE_FRAMES=3).
// Demo scenarios run when MOVE_ARB_DEMO_EN is defined, the demo-disabled scenario otherwise.
module tb_move_cmd_arbiter;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  move_cmd_if bus();
  move_cmd_arbiter #(.DEMO_IDLE_FRAMES(4), .FREEZE_FRAMES(3)) dut (.clk(clk), .resetN(resetN), .bus(bus.slave));
  typedef struct {string n; logic [7:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  wire [7:0] obs = {bus.owner, bus.move_en, bus.demo_active, bus.up_out, bus.down_out, bus.left_out, bus.right_out};
  localparam logic [3:0] R = 4'b0001, L = 4'b0010, D = 4'b0100, U = 4'b1000, N = 4'b0000;

  function automatic logic [7:0] mk(input logic [1:0] o, input logic me, input logic da, input logic [3:0] d);
    return {o, me, da, d};
  endfunction

  task automatic drive(input logic sof, input logic [3:0] k, input logic [3:0] dm, input logic dv,
                       input logic pk, input logic col);
    {bus.kb_up, bus.kb_down, bus.kb_left, bus.kb_right} = k;
    {bus.demo_up, bus.demo_down, bus.demo_left, bus.demo_right} = dm;
    bus.startOfFrame = sof;
    bus.demo_valid   = dv;
    bus.pause_key    = pk;
    bus.collision    = col;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, R, L, 1, 0, 0);
    drive(1, R, L, 1, 0, 1);
    sb.push_back('{"reset_hold", mk(2'b00, 0, 0, N)});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    resetN = 1'b1;
    sb.push_back('{"reset_release", mk(2'b00, 1, 0, N)});
    drive(0, N, N, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    sb.push_back('{"kb_right", mk(2'b00, 1, 0, R)});
    drive(0, R, N, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
  endtask

  task automatic test_kb();
    logic [3:0] pat [3] = '{U | D, L | R, N};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("kb_pass_%0d", i), mk(2'b00, 1, 0, pat[i])});
      drive(0, pat[i], N, 0, 0, 0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    end
  endtask

`ifdef MOVE_ARB_DEMO_EN
  task automatic test_demo();
    for (int i = 1; i <= 4; i++) begin
      sb.push_back('{$sformatf("idle_frame_%0d", i), (i == 4) ? mk(2'b01, 1, 1, L) : mk(2'b00, 1, 0, N)});
      drive(1, N, L, 1, 0, 0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
      drive(0, N, L, 1, 0, 0);
    end
    sb.push_back('{"demo_invalid", mk(2'b00, 1, 0, N)});
    drive(0, N, L, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    for (int i = 0; i < 3; i++) begin drive(1, N, L, 1, 0, 0); drive(0, N, L, 1, 0, 0); end
    drive(0, U, L, 1, 0, 0);
    sb.push_back('{"kb_blocks_switch", mk(2'b00, 1, 0, N)});
    drive(1, N, L, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, R, L, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin drive(1, N, L, 0, 0, 0); drive(0, N, L, 0, 0, 0); end
    sb.push_back('{"idle_saturated", mk(2'b01, 1, 1, L)});
    drive(1, N, L, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
  endtask

  task automatic test_preempt();
    sb.push_back('{"kb_preempt", mk(2'b00, 1, 0, D)});
    drive(0, D, L, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    sb.push_back('{"kb_threshold_tie", mk(2'b00, 1, 0, D)});
    for (int i = 0; i < 3; i++) begin drive(1, N, L, 1, 0, 0); drive(0, N, L, 1, 0, 0); end
    drive(1, D, L, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, L, 1, 0, 0);
  endtask

  task automatic test_pause_demo();
    for (int i = 0; i < 4; i++) begin drive(1, N, L, 1, 0, 0); drive(0, N, L, 1, 0, 0); end
    sb.push_back('{"demo_before_pause", mk(2'b01, 1, 1, L)});
    sb.push_back('{"pause_enter", mk(2'b10, 0, 0, N)});
    sb.push_back('{"pause_held", mk(2'b10, 0, 0, N)});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, L, 1, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    repeat (9) drive(0, N, L, 1, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, L, 1, 0, 0);
    sb.push_back('{"resume_demo", mk(2'b01, 1, 1, L)});
    drive(0, N, L, 1, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, L, 1, 0, 0);
    sb.push_back('{"pause_beats_collision", mk(2'b10, 0, 0, N)});
    drive(0, N, L, 1, 1, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, L, 1, 0, 0);
    sb.push_back('{"resume_demo_2", mk(2'b01, 1, 1, L)});
    drive(0, N, L, 1, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    sb.push_back('{"demo_drop", mk(2'b00, 1, 0, N)});
    drive(0, N, L, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
  endtask
`else
  task automatic test_no_demo();
    for (int i = 1; i <= 20; i++) begin
      sb.push_back('{$sformatf("no_demo_frame_%0d", i), mk(2'b00, 1, 0, N)});
      drive(1, N, L, 1, 0, 0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
      drive(0, N, L, 1, 0, 0);
    end
  endtask
`endif

  task automatic test_freeze();
    sb.push_back('{"freeze_enter", mk(2'b11, 0, 0, N)});
    drive(0, N, N, 0, 0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(1, R, N, 0, 0, 0);
    sb.push_back('{"freeze_recollide", mk(2'b11, 0, 0, N)});
    drive(0, R, N, 0, 0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    sb.push_back('{"freeze_frame2", mk(2'b11, 0, 0, N)});
    drive(1, R, N, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, R, N, 0, 0, 0);
    sb.push_back('{"freeze_done", mk(2'b00, 1, 0, R)});
    drive(1, R, N, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, N, 0, 0, 0);
  endtask

  task automatic test_pause();
    sb.push_back('{"kb_pause", mk(2'b10, 0, 0, N)});
    drive(0, R, N, 0, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, R, N, 0, 0, 0);
    sb.push_back('{"kb_resume", mk(2'b00, 1, 0, R)});
    drive(0, R, N, 0, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, N, 0, 0, 0);
    drive(0, N, N, 0, 0, 1);
    sb.push_back('{"pause_in_freeze", mk(2'b10, 0, 0, N)});
    drive(0, N, N, 0, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    for (int i = 0; i < 3; i++) begin drive(1, N, N, 0, 0, 0); drive(0, N, N, 0, 0, 0); end
    sb.push_back('{"pause_ignores_frames", mk(2'b10, 0, 0, N)});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    sb.push_back('{"freeze_abandoned", mk(2'b00, 1, 0, N)});
    drive(0, N, N, 0, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.n, obs, e.v); end
    drive(0, N, N, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_kb();
`ifdef MOVE_ARB_DEMO_EN
    test_demo();
    test_preempt();
    test_pause_demo();
`endif
    test_freeze();
    test_pause();
`ifndef MOVE_ARB_DEMO_EN
    test_no_demo();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
